// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, round keys fetched
// combinationally from an external key-schedule RAM via rk_idx/rk_data.
module aes_inv_cipher_iter #(
  parameter int unsigned ZEROIZE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [1:0]   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // out_valid/out_data stay stable until that edge, in_data is only sampled on it.

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         r_fsm;
  fsm_t         w_fsm_nxt;
  logic [127:0] r_state;
  logic [127:0] w_state_nxt;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_nxt;
  logic         r_out_valid;
  logic         w_out_valid_nxt;
  logic [127:0] r_out_data;
  logic [127:0] w_out_data_nxt;
  logic [127:0] w_sr;
  logic [127:0] w_sb;
  logic [127:0] w_ark;
  logic [127:0] w_mc;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, x252;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(gmul(gmul(x15, x15), gmul(x15, x15)), gmul(gmul(x15, x15), gmul(x15, x15)));
    x240 = gmul(x240, x240);
    x252 = gmul(x240, x12);
    return gmul(x252, x2);
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = s[8*(4*((c - r) & 3) + r) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[32*c+8 +: 8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[32*c+16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[32*c+24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign w_sr = inv_shift_rows(r_state);
  assign w_sb = inv_sub_bytes(w_sr);
  assign w_ark = w_sb ^ rk_data;
  assign w_mc = inv_mix_columns(w_ark);

  // Kept outside the next-state process so the external rk_idx -> rk_data path is not a loop.
  assign rk_idx    = (r_fsm == ROUND) ? r_cnt : 4'd10;
  assign in_ready  = (r_fsm == IDLE) & ~rst;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign dbg_state = r_fsm;

  always_comb begin
    w_fsm_nxt       = r_fsm;
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    case (r_fsm)
      IDLE: begin
        if (in_valid && in_ready) begin
          w_state_nxt = in_data ^ rk_data;
          w_cnt_nxt   = 4'd9;
          w_fsm_nxt   = ROUND;
        end
      end
      ROUND: begin
        if (r_cnt != 4'd0) begin
          w_state_nxt = w_mc;
          w_cnt_nxt   = r_cnt - 4'd1;
        end else begin
          w_state_nxt     = w_ark;
          w_out_data_nxt  = w_ark;
          w_out_valid_nxt = 1'b1;
          w_fsm_nxt       = DONE;
        end
      end
      DONE: begin
        if (r_out_valid && out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_fsm_nxt       = IDLE;
          if (ZEROIZE != 0) begin
            w_state_nxt    = '0;
            w_out_data_nxt = '0;
          end
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_state     <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter: FIPS-197 C.1 vector, rk_idx trace, back-pressure,
// busy ignore, mid-operation reset and random round trips against a forward-cipher model.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] FIPS_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] FIPS_PT  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] FIPS_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] RK10     = 128'hc5302b4d8ba707f3174a94e37f1d1113;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_data;
  logic         in_ready_z1, in_ready_z0;
  logic [3:0]   rk_idx_z1, rk_idx_z0;
  logic [127:0] rk_data_z1, rk_data_z0;
  logic         out_valid_z1, out_valid_z0;
  logic [127:0] out_data_z1, out_data_z0;
  logic [1:0]   dbg_z1, dbg_z0;
  logic [127:0] rk_ram [0:10];

  int n_pass   = 0;
  int n_checks = 0;
  int n_fail   = 0;

  assign rk_data_z1 = (rk_idx_z1 <= 4'd10) ? rk_ram[rk_idx_z1] : '0;
  assign rk_data_z0 = (rk_idx_z0 <= 4'd10) ? rk_ram[rk_idx_z0] : '0;

  aes_inv_cipher_iter #(.ZEROIZE(1)) dut_z1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_z1), .in_data(in_data),
    .rk_idx(rk_idx_z1), .rk_data(rk_data_z1), .out_valid(out_valid_z1), .out_ready(out_ready),
    .out_data(out_data_z1), .dbg_state(dbg_z1)
  );

  aes_inv_cipher_iter #(.ZEROIZE(0)) dut_z0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_z0), .in_data(in_data),
    .rk_idx(rk_idx_z0), .rk_data(rk_data_z0), .out_valid(out_valid_z0), .out_ready(out_ready),
    .out_data(out_data_z0), .dbg_state(dbg_z0)
  );

  // reference model: forward AES-128 in the same column-major bus packing
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] p;
    inv = 8'h00;
    p   = 8'h01;
    for (int i = 0; i < 254; i++) p = gm(p, x);
    inv = (x == 8'h00) ? 8'h00 : p;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {24'h0, rcon};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_ram[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rk_ram[0];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[8*i +: 8] = sbox(s[8*i +: 8]);
      o = '0;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          o[8*(4*c+r) +: 8] = s[8*(4*((c + r) & 3) + r) +: 8];
      s = o;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[32*c +: 8];
          a1 = s[32*c+8 +: 8];
          a2 = s[32*c+16 +: 8];
          a3 = s[32*c+24 +: 8];
          o[32*c +: 8]    = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          o[32*c+8 +: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          o[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          o[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        s = o;
      end
      s = s ^ rk_ram[rnd];
    end
    return s;
  endfunction

  // scoreboard check
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled just after the falling edge
  task automatic nx();
    @(negedge clk);
  endtask

  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt);
    int lat;
    check("rt_in_ready", 128'(in_ready_z1), 128'(1));
    in_valid = 1'b1;
    in_data  = ct;
    nx();
    in_valid = 1'b0;
    in_data  = '0;
    lat = 0;
    do begin
      nx();
      lat++;
    end while (!out_valid_z1 && lat < 20);
    check("rt_latency", 128'(lat), 128'(10));
    check("rt_data_z1", out_data_z1, pt);
    check("rt_data_z0", out_data_z0, pt);
    check("rt_valid_z0", 128'(out_valid_z0), 128'(1));
    out_ready = 1'b1;
    nx();
    out_ready = 1'b0;
    check("rt_valid_drop", 128'(out_valid_z1), 128'(0));
    check("rt_zeroized", out_data_z1, '0);
    check("rt_retained", out_data_z0, pt);
  endtask

  logic [127:0] pt2, ct2, key_r, pt_r;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    load_key(FIPS_KEY);
    check("model_rk10", rk_ram[10], RK10);
    check("model_encrypt", aes_encrypt(FIPS_PT), FIPS_CT);

    nx();
    nx();
    check("rst_out_valid", 128'(out_valid_z1), 128'(0));
    check("rst_out_data", out_data_z1, '0);
    check("rst_rk_idx", 128'(rk_idx_z1), 128'(10));
    check("rst_in_ready", 128'(in_ready_z1), 128'(0));
    rst = 1'b0;
    nx();
    check("idle_in_ready", 128'(in_ready_z1), 128'(1));

    // FIPS-197 C.1 with rk_idx trace and back-pressure
    check("fips_rk_idx_accept", 128'(rk_idx_z1), 128'(10));
    in_valid = 1'b1;
    in_data  = FIPS_CT;
    nx();
    in_valid = 1'b0;
    in_data  = '0;
    for (int k = 9; k >= 0; k--) begin
      check("fips_rk_idx", 128'(rk_idx_z1), 128'(k));
      check("fips_no_valid", 128'(out_valid_z1), 128'(0));
      check("fips_busy", 128'(in_ready_z1), 128'(0));
      nx();
    end
    check("fips_valid", 128'(out_valid_z1), 128'(1));
    check("fips_data_z1", out_data_z1, FIPS_PT);
    check("fips_data_z0", out_data_z0, FIPS_PT);
    check("fips_rk_idx_done", 128'(rk_idx_z1), 128'(10));
    for (int i = 0; i < 20; i++) begin
      nx();
      check("bp_valid", 128'(out_valid_z1), 128'(1));
      check("bp_data", out_data_z1, FIPS_PT);
      check("bp_in_ready", 128'(in_ready_z1), 128'(0));
      check("bp_rk_idx", 128'(rk_idx_z1), 128'(10));
    end
    out_ready = 1'b1;
    nx();
    out_ready = 1'b0;
    check("hs_valid_drop", 128'(out_valid_z1), 128'(0));
    check("hs_in_ready", 128'(in_ready_z1), 128'(1));
    check("hs_zeroize_z1", out_data_z1, '0);
    check("hs_retain_z0", out_data_z0, FIPS_PT);

    // busy ignore: second block held on in_data throughout the first operation
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    ct2 = aes_encrypt(pt2);
    in_valid  = 1'b1;
    in_data   = FIPS_CT;
    out_ready = 1'b1;
    nx();
    in_data = ct2;
    for (int i = 1; i <= 11; i++) begin
      nx();
      check("busy_valid", 128'(out_valid_z1), 128'(i == 10));
      if (i == 10) check("busy_first_data", out_data_z1, FIPS_PT);
      check("busy_in_ready", 128'(in_ready_z1), 128'(i == 11));
    end
    nx();
    in_valid = 1'b0;
    in_data  = '0;
    check("busy_second_accepted", 128'(in_ready_z1), 128'(0));
    repeat (10) nx();
    check("busy_second_valid", 128'(out_valid_z1), 128'(1));
    check("busy_second_data", out_data_z1, pt2);
    nx();
    out_ready = 1'b0;
    check("busy_second_drop", 128'(out_valid_z1), 128'(0));

    // reset in the middle of a block
    in_valid = 1'b1;
    in_data  = FIPS_CT;
    nx();
    in_valid = 1'b0;
    in_data  = '0;
    repeat (4) nx();
    check("mid_rk_idx5", 128'(rk_idx_z1), 128'(5));
    rst = 1'b1;
    nx();
    check("mid_rst_rk_idx", 128'(rk_idx_z1), 128'(10));
    check("mid_rst_data_z0", out_data_z0, '0);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      nx();
      check("mid_no_valid", 128'(out_valid_z1 | out_valid_z0), 128'(0));
      check("mid_in_ready", 128'(in_ready_z1), 128'(1));
    end
    run_block(FIPS_CT, FIPS_PT);

    // random round trips
    for (int n = 0; n < 100; n++) begin
      key_r = {$urandom, $urandom, $urandom, $urandom};
      pt_r  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key_r);
      run_block(aes_encrypt(pt_r), pt_r);
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
